data_sram_slave: RTL and testbench
==================================

# data_sram_slave

Responder end of the core's data SRAM interface: accepts the single-cycle `en/wen/addr/wdata` requests the core issues and returns `rdata` with fixed one-cycle latency. Requests are served from two places:
- an internal word-organised RAM with byte-lane writes;
- a small MMIO register window: LED register, free-running timer, compare interrupt.

It sits beside the CPU core at top level. `timer_int` is wired to the core's `int[5]`.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width. Depth is 2^RAM_AW words; the RAM index is `addr[RAM_AW+1:2]`.
- `MMIO_BASE`, 16'hBFAF: value of `addr[31:16]` that selects the MMIO window.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  4  byte-lane write enables. 4'b0000 = read.
- `data_sram_addr`  in  32  byte address. Bits [1:0] are ignored.
- `data_sram_wdata`  in  32  write data. Lane i = bits [8i+7:8i].
- `data_sram_rdata`  out  32  read data, registered.
- `led`  out  16  LED register contents.
- `timer_int`  out  1  timer interrupt request, level.

## Operation
- **Decode:** MMIO when `addr[31:16]==MMIO_BASE`; otherwise RAM. RAM aliases modulo its depth.
- **RAM write:** when `en && wen!=0`, write each enabled lane of the addressed word; disabled lanes are unchanged.
- **RAM read:** when `en && wen==0`, `rdata` <= the addressed word.
- **Read-during-write:** a write cycle does not update `rdata`; it holds its previous value.
- **MMIO registers** (offset = `addr[15:0]`). Writes honour lanes; unmapped offsets read 0 and ignore writes.
  - 0x0000 `COUNT`, RW: timer counter.
  - 0x0004 `COMPARE`, RW.
  - 0x0008 `CTRL`, RW bits[1:0]: bit0 = timer run, bit1 = interrupt enable. Other bits read 0.
  - 0x000C `STATUS`: bit0 = match pending, sticky. Writing 1 to bit0 clears it (write-1-clear, W1C). Other bits read 0.
  - 0x0010 `LED`, RW bits[15:0]. Upper bits read 0.
- **Timer:**
  - While `CTRL[0]`, `COUNT` increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - A CPU write to `COUNT` in the same cycle overrides the increment; written lanes take `wdata`, the rest keep their old value (no increment).
- **Match:** when `CTRL[0] && COUNT==COMPARE`, compared on the pre-update value, `STATUS[0]` <= 1.
  - If a match and a W1C land in the same cycle, the set wins.
- **Interrupt:** `timer_int = STATUS[0] & CTRL[1]`. It is driven from flops only.
- **Idle:** `en==0` means no state change except the timer; `rdata` holds.

## Timing
- **Read latency:** exactly 1 cycle. Request at edge N, `rdata` valid after edge N+1, held until the next read.
- **Throughput:** one access per cycle, back-to-back, no stall or back-pressure. Read-after-write to the same address in consecutive cycles returns the new data.
- **Interrupt timing:**
  - A match detected at edge N sets `STATUS[0]` at edge N+1.
  - `timer_int` follows combinationally from the flops, so it rises after edge N+1.
  - W1C at edge N drops `timer_int` after edge N+1.
- **Reset values:** `rdata`=0, `COUNT`=0, `COMPARE`=32'hFFFF_FFFF, `CTRL`=0, `STATUS`=0, `led`=0, `timer_int`=0. RAM contents are not reset.
- **Reset mid-operation:** asserting `rst` clears all registers immediately, independent of `clk`. A write in flight when reset is asserted is discarded. After release, the first edge behaves as idle-from-reset.

## Configuration
- Macro `DATA_SRAM_SLAVE_TIMER_EN`.
- Defined: timer logic present (`COUNT`, `COMPARE`, `CTRL`, `STATUS`, `timer_int`) as specified above.
- Undefined: no timer flops. Offsets 0x0000–0x000C read 0 and ignore writes; `timer_int` is tied 0. RAM and `LED` are unchanged.

## Test plan
- **Byte-lane write:** write 32'h1122_3344 to 0x0000_0100 with wen=4'hF, then 32'hAABB_CCDD with wen=4'b0101, then read. Required: `rdata`=32'h11BB_33DD one cycle after the read request.
- **Back-to-back and hold:** read 0x100 and 0x104 on consecutive cycles; each word appears exactly one cycle after its request. Then idle 3 cycles; `rdata` holds the 0x104 value.
- **LED:** write 32'hFFFF_A5A5 to 0xBFAF_0010. Required: `led`=16'hA5A5, and a read returns 32'h0000_A5A5.
- **Timer match** (macro on):
  - Setup: `COMPARE`=10, `COUNT`=0, `CTRL`=3.
  - Required: `timer_int` rises exactly 11 cycles after the `CTRL` write. W1C `STATUS`=1 drops it 1 cycle later.
  - Match on W1C cycle: force a match on the same cycle as the W1C; `STATUS[0]` stays 1.
- **Reset mid-run:**
  - Setup: `COUNT` running, `led`=16'h00FF, `STATUS[0]`=1.
  - Stimulus: pulse `rst` low between clock edges.
  - Required: all outputs and registers return to their reset values immediately; a previously written RAM word still reads back its data.
- **Macro off:** read 0xBFAF_0000 returns 0. `timer_int` stays 0 after setting `CTRL`=3 and `COMPARE`=0.

Source files
------------

// File: rtl/data_sram_slave_if.sv
// Data SRAM request/response bundle between the core (master) and its responder (slave).
// Signals: en/wen/addr/wdata from the core, rdata back from the responder one cycle later.
// No flow control: the core may issue one request every cycle.
interface data_sram_slave_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_slave.sv
// Data SRAM responder: word RAM with byte-lane writes plus an MMIO window (LED, timer, compare irq).
// Latency: registered rdata one cycle after a read request; writes never update rdata.
// Backpressure: none, accepts one access every cycle.
// Ports: clk, rst (async active-low), bus (slave modport), led[15:0], timer_int.
// Optional timer block (COUNT/COMPARE/CTRL/STATUS, timer_int) built when DATA_SRAM_SLAVE_TIMER_EN is defined.
module data_sram_slave #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
    input  logic                  clk,
    input  logic                  rst,
    data_sram_slave_if.slave      bus,
    output logic [15:0]           led,
    output logic                  timer_int
);

    // Merge write data into an existing word honouring the byte-lane enables.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    logic              is_mmio;
    logic              wr;
    logic              rd;
    logic              ram_wr;
    logic              mmio_wr;
    logic [13:0]       off;
    logic              sel_led;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       mmio_rdata;
    logic [31:0]       rdata_q;
    logic [31:0]       mem [2**RAM_AW];

    // Address bits below word granularity never matter.
    logic              unused_bits;
    assign unused_bits = ^{bus.data_sram_addr[1:0], bus.data_sram_wdata[31:16]};

    assign is_mmio = (bus.data_sram_addr[31:16] == MMIO_BASE);
    assign wr      = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    assign rd      = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign ram_wr  = wr && !is_mmio;
    assign mmio_wr = wr && is_mmio;
    assign off     = bus.data_sram_addr[15:2];
    assign sel_led = (off == 14'h0004);
    assign ram_idx = bus.data_sram_addr[RAM_AW+1:2];

    // RAM contents survive reset; a write presented while rst is low is dropped.
    always_ff @(posedge clk) begin
        if (rst && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) mem[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 16'h0000;
        end else if (mmio_wr && sel_led) begin
            if (bus.data_sram_wen[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
            if (bus.data_sram_wen[1]) led[15:8] <= bus.data_sram_wdata[15:8];
        end
    end

`ifdef DATA_SRAM_SLAVE_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic [1:0]  ctrl;
    logic        status;
    logic        sel_count;
    logic        sel_compare;
    logic        sel_ctrl;
    logic        sel_status;
    logic        match;

    assign sel_count   = (off == 14'h0000);
    assign sel_compare = (off == 14'h0001);
    assign sel_ctrl    = (off == 14'h0002);
    assign sel_status  = (off == 14'h0003);
    // Compared on the value before this edge's update.
    assign match       = ctrl[0] && (count == compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= 32'h0000_0000;
            compare <= 32'hFFFF_FFFF;
            ctrl    <= 2'b00;
            status  <= 1'b0;
        end else begin
            // A CPU write to COUNT replaces the increment for that cycle.
            if (mmio_wr && sel_count)
                count <= lane_merge(count, bus.data_sram_wdata, bus.data_sram_wen);
            else if (ctrl[0])
                count <= count + 32'd1;

            if (mmio_wr && sel_compare)
                compare <= lane_merge(compare, bus.data_sram_wdata, bus.data_sram_wen);

            if (mmio_wr && sel_ctrl && bus.data_sram_wen[0])
                ctrl <= bus.data_sram_wdata[1:0];

            // Set beats write-1-clear so a match in the clearing cycle is not lost.
            if (match)
                status <= 1'b1;
            else if (mmio_wr && sel_status && bus.data_sram_wen[0] && bus.data_sram_wdata[0])
                status <= 1'b0;
        end
    end

    assign timer_int = status & ctrl[1];

    always_comb begin
        mmio_rdata = 32'h0000_0000;
        case (off)
            14'h0000: mmio_rdata = count;
            14'h0001: mmio_rdata = compare;
            14'h0002: mmio_rdata = {30'h0, ctrl};
            14'h0003: mmio_rdata = {31'h0, status};
            14'h0004: mmio_rdata = {16'h0, led};
            default:  mmio_rdata = 32'h0000_0000;
        endcase
    end
`else
    assign timer_int = 1'b0;

    always_comb begin
        mmio_rdata = 32'h0000_0000;
        if (sel_led) mmio_rdata = {16'h0, led};
    end
`endif

    // Only reads load rdata; writes and idle cycles hold the last read value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata_q <= 32'h0000_0000;
        else if (rd)
            rdata_q <= is_mmio ? mmio_rdata : mem[ram_idx];
    end

    assign bus.data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
module tb_data_sram_slave;
    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        timer_int;
    int          checks;
    int          errors;

    data_sram_slave_if bus();

    data_sram_slave dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .led       (led),
        .timer_int (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [19];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Present one request, let it be sampled, then sample outputs 1 time unit after the edge.
    task automatic access(input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
    endtask

    task automatic idle();
        access(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344, 32'h0000_0000, 16'h0000};
        vecs[1]  = '{1'b1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 32'h0000_0000, 16'h0000};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 16'h0000};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'h11BB_33DD, 16'h0000};
        vecs[4]  = '{1'b1, 4'h0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 16'h0000};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,         32'h0,         32'hDEAD_BEEF, 16'h0000};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,         32'h0,         32'hDEAD_BEEF, 16'h0000};
        vecs[7]  = '{1'b0, 4'h0, 32'h0,         32'h0,         32'hDEAD_BEEF, 16'h0000};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_4100, 32'h0,         32'h11BB_33DD, 16'h0000};
        vecs[9]  = '{1'b1, 4'hF, 32'hBFAF_0010, 32'hFFFF_A5A5, 32'h11BB_33DD, 16'hA5A5};
        vecs[10] = '{1'b1, 4'h0, 32'hBFAF_0010, 32'h0,         32'h0000_A5A5, 16'hA5A5};
        vecs[11] = '{1'b1, 4'h3, 32'hBFAF_0010, 32'h0000_00FF, 32'h0000_A5A5, 16'h00FF};
        vecs[12] = '{1'b1, 4'h0, 32'hBFAF_0000, 32'h0,         32'h0000_0000, 16'h00FF};
        vecs[13] = '{1'b1, 4'h0, 32'hBFAF_0020, 32'h0,         32'h0000_0000, 16'h00FF};
        vecs[14] = '{1'b1, 4'hF, 32'h0000_0108, 32'hCAFE_F00D, 32'h0000_0000, 16'h00FF};
        vecs[15] = '{1'b1, 4'h0, 32'h0000_0108, 32'h0,         32'hCAFE_F00D, 16'h00FF};
        vecs[16] = '{1'b1, 4'h0, 32'h0000_0101, 32'h0,         32'h11BB_33DD, 16'h00FF};
        vecs[17] = '{1'b1, 4'hF, 32'hBFAF_0014, 32'hFFFF_FFFF, 32'h11BB_33DD, 16'h00FF};
        vecs[18] = '{1'b1, 4'h0, 32'hBFAF_0014, 32'h0,         32'h0000_0000, 16'h00FF};

        #2;
        check32("reset_rdata", bus.data_sram_rdata, 32'h0);
        check32("reset_led", {16'h0, led}, 32'h0);
        check32("reset_timer_int", {31'h0, timer_int}, 32'h0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            access(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            check32($sformatf("vec%0d_rdata", i), bus.data_sram_rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
            check32($sformatf("vec%0d_timer_int", i), {31'h0, timer_int}, 32'h0);
        end

`ifdef DATA_SRAM_SLAVE_TIMER_EN
        access(1'b1, 4'hF, 32'hBFAF_0004, 32'd10);
        access(1'b1, 4'hF, 32'hBFAF_0000, 32'd0);
        access(1'b1, 4'hF, 32'hBFAF_0008, 32'd3);
        for (int k = 1; k <= 11; k++) begin
            idle();
            check32($sformatf("match_wait%0d", k), {31'h0, timer_int}, (k == 11) ? 32'h1 : 32'h0);
        end
        access(1'b1, 4'hF, 32'hBFAF_000C, 32'h1);
        check32("w1c_drop", {31'h0, timer_int}, 32'h0);
        access(1'b1, 4'hF, 32'hBFAF_0004, 32'd100);
        access(1'b1, 4'hF, 32'hBFAF_0000, 32'd99);
        check32("count_override_int", {31'h0, timer_int}, 32'h0);
        idle();
        access(1'b1, 4'hF, 32'hBFAF_000C, 32'h1);
        check32("match_beats_w1c", {31'h0, timer_int}, 32'h1);
        access(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
        check32("status_read", bus.data_sram_rdata, 32'h1);
`else
        access(1'b1, 4'hF, 32'hBFAF_0008, 32'd3);
        access(1'b1, 4'hF, 32'hBFAF_0004, 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle();
            check32($sformatf("noTimer_int%0d", k), {31'h0, timer_int}, 32'h0);
        end
        access(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        check32("noTimer_ctrl_read", bus.data_sram_rdata, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        check32("noTimer_count_read", bus.data_sram_rdata, 32'h0);
`endif

        // Reset pulse between edges with a RAM write in flight.
        access(1'b1, 4'h0, 32'h0000_0104, 32'h0);
        check32("pre_reset_rdata", bus.data_sram_rdata, 32'hDEAD_BEEF);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = 32'h0000_0100;
        bus.data_sram_wdata = 32'h5555_5555;
        #1 rst = 1'b0;
        #1;
        check32("midrst_rdata", bus.data_sram_rdata, 32'h0);
        check32("midrst_led", {16'h0, led}, 32'h0);
        check32("midrst_timer_int", {31'h0, timer_int}, 32'h0);
        @(posedge clk);
        #1;
        bus.data_sram_en = 1'b0;
        bus.data_sram_wen = 4'h0;
        rst = 1'b1;
        idle();
        check32("post_rst_idle_rdata", bus.data_sram_rdata, 32'h0);
        check32("post_rst_idle_led", {16'h0, led}, 32'h0);
        access(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        check32("ram_survives_reset", bus.data_sram_rdata, 32'h11BB_33DD);
        access(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
        check32("led_reg_reset", bus.data_sram_rdata, 32'h0);
`ifdef DATA_SRAM_SLAVE_TIMER_EN
        access(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        check32("count_reset", bus.data_sram_rdata, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("compare_reset", bus.data_sram_rdata, 32'hFFFF_FFFF);
        access(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        check32("ctrl_reset", bus.data_sram_rdata, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
        check32("status_reset", bus.data_sram_rdata, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
